// File: rtl/cdim_bus_pkg.sv
// Shared types for the CPU memory-bus arbiter: FSM states, port ownership and
// transfer size encodings.
package cdim_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StWait
  } state_e;

  typedef enum logic {
    OwnInst,
    OwnData
  } owner_e;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

endpackage

// File: rtl/arb_pick.sv
// Two-way request picker: a lone requester always wins; on a tie the port
// selected by prio_data_i wins.
module arb_pick (
  input  logic inst_req_i,
  input  logic data_req_i,
  input  logic prio_data_i,
  output logic valid_o,
  output logic grant_data_o
);

  always_comb begin
    valid_o      = inst_req_i | data_req_i;
    grant_data_o = 1'b1;
    if (inst_req_i && data_req_i) begin
      grant_data_o = prio_data_i;
    end else if (inst_req_i) begin
      grant_data_o = 1'b0;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter sharing one SRAM-style bus between fetch and data ports.
// Define ARB_ROUND_ROBIN_EN to alternate priority on ties instead of data-first.
module mem_bus_arbiter
  import cdim_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_cancel,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              i_stall,
  output logic              d_stall
);

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic               drop_q, drop_d;
  logic               req_q, req_d;
  logic               wr_q, wr_d;
  logic [1:0]         size_q, size_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               pick_valid, pick_data, prio_data;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e rr_q, rr_d;
  assign prio_data = (rr_q == OwnData);
`else
  assign prio_data = 1'b1;
`endif

  arb_pick u_arb_pick (
    .inst_req_i   (inst_req),
    .data_req_i   (data_req),
    .prio_data_i  (prio_data),
    .valid_o      (pick_valid),
    .grant_data_o (pick_data)
  );

  logic inst_busy, data_busy, inst_cut;
  assign inst_busy = (state_q != StIdle) && (owner_q == OwnInst);
  assign data_busy = (state_q != StIdle) && (owner_q == OwnData);
  assign inst_cut  = inst_busy && inst_cancel;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    drop_d  = drop_q;
    req_d   = req_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_d    = rr_q;
`endif
    unique case (state_q)
      StIdle: begin
        drop_d = 1'b0;
        if (pick_valid) begin
          state_d = StAddr;
          owner_d = pick_data ? OwnData : OwnInst;
          req_d   = 1'b1;
          wr_d    = pick_data ? data_wr : 1'b0;
          size_d  = pick_data ? data_size : SizeWord;
          addr_d  = pick_data ? data_addr : inst_addr;
          wdata_d = pick_data ? data_wdata : '0;
`ifdef ARB_ROUND_ROBIN_EN
          rr_d    = pick_data ? OwnInst : OwnData;
`endif
        end
      end
      StAddr: begin
        if (inst_cut) drop_d = 1'b1;
        // A data response here is a downstream protocol error and is ignored.
        if (bus_addr_ok) begin
          req_d   = 1'b0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (inst_cut) drop_d = 1'b1;
        if (bus_data_ok) begin
          state_d = StIdle;
          drop_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      owner_q <= OwnData;
      drop_q  <= 1'b0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q    <= OwnData;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign bus_req   = req_q;
  assign bus_wr    = wr_q;
  assign bus_size  = size_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

  always_comb begin
    inst_addr_ok = (state_q == StAddr) && bus_addr_ok && (owner_q == OwnInst);
    data_addr_ok = (state_q == StAddr) && bus_addr_ok && (owner_q == OwnData);
    // Same-cycle cancel also suppresses the fetch data, not just a latched drop.
    inst_data_ok = (state_q == StWait) && bus_data_ok && (owner_q == OwnInst)
                   && !drop_q && !inst_cancel;
    data_data_ok = (state_q == StWait) && bus_data_ok && (owner_q == OwnData);
    inst_rdata   = inst_data_ok ? bus_rdata : '0;
    data_rdata   = data_data_ok ? bus_rdata : '0;
    i_stall      = (inst_req || (inst_busy && !drop_q)) && !inst_data_ok;
    d_stall      = (data_req || data_busy) && !data_data_ok;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a transaction scoreboard; honours
// ARB_ROUND_ROBIN_EN when predicting tie-break winners.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_cancel, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        i_stall, d_stall;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_cancel  (inst_cancel),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata),
    .i_stall      (i_stall),
    .d_stall      (d_stall)
  );

  typedef struct {
    bit          own_data;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] rdata_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          ptr_data = 1'b1;  // which port wins a tie next

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_cycle(input string tag, input bit own_data, input bit drop_m,
                           input bit busy, input bit iok, input bit dok);
    logic ei, ed;
    ei = (inst_req | (busy & !own_data & !drop_m)) & !iok;
    ed = (data_req | (busy & own_data)) & !dok;
    chk({tag, "_i_stall"}, 32'(i_stall), 32'(ei));
    chk({tag, "_d_stall"}, 32'(d_stall), 32'(ed));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_bus_wr"}, 32'(bus_wr), 32'd0);
    chk({tag, "_bus_size"}, 32'(bus_size), 32'd0);
    chk({tag, "_bus_addr"}, bus_addr, 32'd0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_oks"}, 32'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 32'd0);
    chk({tag, "_rdata"}, inst_rdata | data_rdata, 32'd0);
    chk({tag, "_stalls"}, 32'({i_stall, d_stall}), 32'd0);
  endtask

  // Called in an IDLE cycle with requests already driven; runs one full transaction.
  task automatic serve(input int addr_dly, input int data_dly, input logic [31:0] rdata,
                       input bit cancel, input bit rereq, input bit side_req);
    txn_t        e;
    int          n;
    bit          drop_m, iok, dok;
    logic [31:0] er;
    e.own_data = data_req && (!inst_req || ptr_data);
`ifdef ARB_ROUND_ROBIN_EN
    ptr_data = !e.own_data;
`endif
    if (e.own_data) begin
      e.wr = data_wr; e.size = data_size; e.addr = data_addr; e.wdata = data_wdata;
    end else begin
      e.wr = 1'b0; e.size = 2'b10; e.addr = inst_addr; e.wdata = 32'd0;
    end
    exp_q.push_back(e);
    step(); inst_cancel = 1'b0; #1;
    n = 0;
    while (bus_req !== 1'b1 && n < 8) begin
      step(); #1; n++;
    end
    chk("grant_latency", 32'(n), 32'd0);
    e = exp_q.pop_front();
    chk("bus_wr", 32'(bus_wr), 32'(e.wr));
    chk("bus_size", 32'(bus_size), 32'(e.size));
    chk("bus_addr", bus_addr, e.addr);
    chk("bus_wdata", bus_wdata, e.wdata);
    drop_m = 1'b0;
    for (int i = 0; i < addr_dly; i++) begin
      bus_data_ok = (i == 0);  // stray response while in ADDR
      #1;
      chk("addr_hold_req", 32'(bus_req), 32'd1);
      chk("addr_hold_addr", bus_addr, e.addr);
      chk("addr_no_data_ok", 32'(inst_data_ok | data_data_ok), 32'd0);
      chk_cycle("addr_wait", e.own_data, drop_m, 1'b1, 1'b0, 1'b0);
      step(); bus_data_ok = 1'b0;
    end
    bus_addr_ok = 1'b1; #1;
    chk("inst_addr_ok", 32'(inst_addr_ok), 32'(!e.own_data));
    chk("data_addr_ok", 32'(data_addr_ok), 32'(e.own_data));
    chk_cycle("addr_ok", e.own_data, drop_m, 1'b1, 1'b0, 1'b0);
    step(); bus_addr_ok = 1'b0;
    if (e.own_data) begin
      data_req = rereq;
      if (rereq) data_addr = data_addr + 32'h100;
    end else begin
      inst_req = rereq;
      if (rereq) inst_addr = inst_addr + 32'd4;
    end
    if (side_req) begin
      if (e.own_data) begin
        inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
      end else begin
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'b10; data_addr = 32'h8000_0040;
      end
    end
    if (cancel) inst_cancel = 1'b1;
    #1;
    chk("wait_req_low", 32'(bus_req), 32'd0);
    for (int i = 0; i < data_dly; i++) begin
      chk_cycle("wait", e.own_data, drop_m, 1'b1, 1'b0, 1'b0);
      step();
      if (inst_cancel && !e.own_data) drop_m = 1'b1;
      inst_cancel = 1'b0;
      #1;
    end
    bus_data_ok = 1'b1; bus_rdata = rdata; rdata_q.push_back(rdata); #1;
    iok = !e.own_data && !drop_m && !inst_cancel;
    dok = e.own_data;
    er  = rdata_q.pop_front();
    chk("inst_data_ok", 32'(inst_data_ok), 32'(iok));
    chk("data_data_ok", 32'(data_data_ok), 32'(dok));
    chk("inst_rdata", inst_rdata, iok ? er : 32'd0);
    chk("data_rdata", data_rdata, dok ? er : 32'd0);
    chk_cycle("data_ok", e.own_data, drop_m, 1'b1, iok, dok);
    step(); bus_data_ok = 1'b0; bus_rdata = 32'd0; inst_cancel = 1'b0; #1;
    chk("idle_req_low", 32'(bus_req), 32'd0);
    chk_cycle("idle", e.own_data, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; inst_req = 1'b0; inst_addr = 32'd0; inst_cancel = 1'b0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'b00; data_addr = 32'd0;
    data_wdata = 32'd0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
    step(); step(); #1;
    chk_zero("in_reset");
    step(); resetn = 1'b1; #1;
    chk_zero("post_reset");

    // Single fetch at the boot vector, minimum latency.
    step(); inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    serve(0, 0, 32'h3C01_0001, 1'b0, 1'b0, 1'b0);

    // Simultaneous fetch and store.
    step(); inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'b10;
    data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
    serve(0, 1, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    serve(1, 0, 32'h2402_0005, 1'b0, 1'b0, 1'b0);

    // Three contested rounds; the winner re-requests in the first two.
    step(); inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'b00;
    data_addr = 32'h8000_0101; data_wdata = 32'h0;
    serve(0, 0, 32'hA1A1_0001, 1'b0, 1'b1, 1'b0);
    serve(0, 0, 32'hA1A1_0002, 1'b0, 1'b1, 1'b0);
    serve(0, 0, 32'hA1A1_0003, 1'b0, 1'b0, 1'b0);
    serve(0, 0, 32'hA1A1_0004, 1'b0, 1'b0, 1'b0);

    // Cancel during WAIT with a data load queued behind the fetch.
    step(); inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
    serve(0, 2, 32'h1111_1111, 1'b1, 1'b0, 1'b1);
    serve(0, 0, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0);

    // Cancel in the same cycle as the bus data.
    step(); inst_req = 1'b1; inst_addr = 32'hBFC0_0300;
    serve(0, 0, 32'h2222_2222, 1'b1, 1'b0, 1'b0);

    // Cancel in IDLE, then a half-word store with a slow address phase.
    step(); data_req = 1'b1; data_wr = 1'b1; data_size = 2'b01;
    data_addr = 32'h8000_0022; data_wdata = 32'h0000_BEEF; inst_cancel = 1'b1;
    serve(4, 1, 32'h0000_0000, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while in ADDR.
    step(); data_req = 1'b1; data_wr = 1'b0; data_size = 2'b10; data_addr = 32'h8000_0030;
    step(); #1;
    chk("pre_reset_bus_req", 32'(bus_req), 32'd1);
    #2 resetn = 1'b0;
    #1 chk("async_bus_req_drop", 32'(bus_req), 32'd0);
    data_req = 1'b0; bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    ptr_data = 1'b1;
    step(); step(); resetn = 1'b1; #1;
    chk_zero("reset_release");
    step(); #1;
    chk_zero("late_response");
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates one SRAM-style memory bus between the instruction-fetch port and the data-access port of the CPU core. It admits exactly one transaction at a time, latches the winning request, and forwards the address and data handshakes. It generates the `i_stall` and `d_stall` levels consumed by the pipeline hazard unit. It sits between the fetch/memory stages and the cache/bus bridge.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk`  in  1  core clock; all state changes on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `inst_req`, `inst_addr`  in  1/ADDR_W  fetch request; held until `inst_addr_ok`; always a read of size 2'b10.
- `inst_cancel`  in  1  branch/exception flush; drops the data of an in-flight fetch.
- `inst_addr_ok`, `inst_data_ok`  out  1/1  fetch handshake pulses.
- `inst_rdata`  out  DATA_W  fetch read data, valid with `inst_data_ok`.
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wdata`  in  1/1/2/ADDR_W/DATA_W  data request; held until `data_addr_ok`.
- `data_addr_ok`, `data_data_ok`  out  1/1  data handshake pulses.
- `data_rdata`  out  DATA_W  data read data.
- `bus_req`, `bus_wr`, `bus_size`, `bus_addr`, `bus_wdata`  out  1/1/2/ADDR_W/DATA_W  downstream request, all registered.
- `bus_addr_ok`, `bus_data_ok`  in  1/1  downstream handshake.
- `bus_rdata`  in  DATA_W  downstream read data.
- `i_stall`, `d_stall`  out  1/1  stall levels to the hazard unit.

## Operation
- FSM states:
  - IDLE: no transaction. If any request is pending, arbitrate, latch the winner's owner, wr, size, addr and wdata into the `bus_*` registers, and go to ADDR.
  - ADDR: `bus_req`=1. On `bus_addr_ok`, pulse the owner's `*_addr_ok` in the same cycle, drop `bus_req`, and go to WAIT.
  - WAIT: on `bus_data_ok`, forward `bus_data_ok` and `bus_rdata` combinationally to the owner and return to IDLE.
- Default priority: data beats instruction when both request in IDLE.
- Cancel: `inst_cancel` while an instruction transaction is in ADDR or WAIT sets a `drop` flag.
  - The transaction still completes on the bus.
  - Its `inst_data_ok` is suppressed.
  - `drop` clears on return to IDLE.
  - `inst_cancel` in IDLE has no effect on a data transaction.
- Stall levels:
  - `i_stall = inst_req | (owner==INST & state!=IDLE & ~drop)`, minus the cycle in which `inst_data_ok`=1.
  - `d_stall` is defined the same way for the data port, without a drop flag.
- Outputs are zero whenever the port is not the owner.

## Timing
- Reset values:
  - state=IDLE.
  - All `bus_*` outputs 0.
  - All `*_ok` outputs 0.
  - drop=0.
  - Round-robin pointer = DATA.
- Minimum latency: request in cycle 0 → `bus_req` in cycle 1.
  - If `bus_addr_ok` arrives in cycle 1 and `bus_data_ok` in cycle 2, the requester sees `addr_ok` in cycle 1 and `data_ok` in cycle 2.
- Back-to-back requests have at least one IDLE cycle between transactions.
- `bus_data_ok` while in ADDR is a downstream protocol violation and is ignored.
- Asynchronous reset mid-transaction: the FSM returns to IDLE and `bus_req` drops immediately. Downstream responses that arrive afterwards are ignored.
- `inst_cancel` and `bus_data_ok` in the same cycle: the data is suppressed.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: when both ports request in IDLE, the port that did not win the previous grant wins. The pointer updates on every grant.
- Not defined: fixed data-over-instruction priority, and no pointer register.

## Structure
- `cdim_bus_pkg` holds:
  - the state enum (IDLE/ADDR/WAIT);
  - the owner enum (INST/DATA);
  - size encodings (BYTE=2'b00, HALF=2'b01, WORD=2'b10).
- One sub-module, `arb_pick`: combinational two-way priority picker taking both requests plus the pointer, and returning the grant.

## Test plan
- Single fetch, addr 0xBFC00000:
  - `bus_req` asserts 1 cycle later, with `bus_wr`=0 and `bus_size`=2'b10.
  - With `bus_rdata`=0x3C010001, `inst_rdata`=0x3C010001 on `inst_data_ok`.
  - `i_stall` deasserts in that cycle.
- Simultaneous fetch and store (addr 0x80000010, wdata 0xDEADBEEF, size 2'b10), fixed priority:
  - Store is granted first; `bus_wr`=1.
  - `i_stall`=1 throughout; the fetch is issued after IDLE.
- Same stimulus repeated three times with `ARB_ROUND_ROBIN_EN`: grants alternate DATA, INST, DATA.
- `inst_cancel` during WAIT of a fetch:
  - `bus_data_ok` arrives but `inst_data_ok` stays 0.
  - FSM returns to IDLE.
  - A queued data request is granted next.
- Downstream `bus_addr_ok` delayed 4 cycles: `bus_req` stays 1 with a stable address; `d_stall`=1 for all cycles.
- `resetn` low during ADDR: `bus_req`=0 immediately; after release, state=IDLE and all outputs 0.
